fir_mac_seq: RTL and testbench

Operand sequencer and result collector for one FIR output on the unified-format FP ALU. It runs NTAPS multiplies of FP16 coefficients by denormalized samples back-to-back. It then accumulates the products with dependent adds and returns one 29-bit unified-format result over a valid/ready handshake. The ALU has no valid or tag signals, so this block tracks in-flight operations itself with a LAT-deep issue-tag shift register.

---
 rtl/fir_mac_seq.sv | 182 ++++++++++++++++++
 tb/tb_fir_mac_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_seq.sv
// fir_mac_seq: issues NTAPS coefficient x sample multiplies and the dependent accumulate adds
// on a tagless fixed-latency FP ALU. Optional zero-sample skipping: FIR_SEQ_ZEROSKIP_EN.
//
// state | meaning
// IDLE  | waiting for start
// MUL   | one multiply per cycle, tap = idx_q
// MWAIT | draining product tags
// ADD   | one add: accumulator + next pending product
// AWAIT | waiting for that add's result
// DONE  | y_valid high until y_ready
module fir_mac_seq #(
    parameter int NTAPS   = 8,
    parameter int ALU_LAT = 4,
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic [AW-1:0] coef_addr_o,
    output logic [AW-1:0] smp_addr_o,
    input  logic [15:0]   coef_data_i,
    input  logic [16:0]   smp_data_i,
    output logic          alu_a_sgn_o,
    output logic          alu_b_sgn_o,
    output logic [5:0]    alu_a_exp_o,
    output logic [5:0]    alu_b_exp_o,
    output logic [21:0]   alu_a_man_dn_o,
    output logic [21:0]   alu_b_man_dn_o,
    output logic          alu_add_muln_o,
    input  logic          alu_y_sgn_i,
    input  logic [5:0]    alu_y_exp_i,
    input  logic [21:0]   alu_y_man_dn_i,
    output logic          y_valid_o,
    input  logic          y_ready_i,
    output logic          y_sgn_o,
    output logic [5:0]    y_exp_o,
    output logic [21:0]   y_man_dn_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_MWAIT = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_AWAIT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [NTAPS-1:0]   pend_q, pend_d;
    logic [28:0]        acc_q, acc_d;
    logic               acc_vld_q, acc_vld_d;
    logic [28:0]        prod_q [NTAPS];
    logic [ALU_LAT-1:0] tv_q, tk_q, ts_q;
    logic [AW-1:0]      ti_q [ALU_LAT];

    logic               mul_iss, add_iss, inflight, ret_mul, ret_add;
    logic [AW-1:0]      sel;
    logic [28:0]        prod_word;

    // The ALU never produces a product sign; it travels in the tag instead.
    assign prod_word = {ts_q[ALU_LAT-1], alu_y_exp_i, alu_y_man_dn_i};
    assign ret_mul   = tv_q[ALU_LAT-1] & ~tk_q[ALU_LAT-1];
    assign ret_add   = tv_q[ALU_LAT-1] & tk_q[ALU_LAT-1];

`ifdef FIR_SEQ_ZEROSKIP_EN
    assign mul_iss = (state_q == S_MUL) && (smp_data_i[10:0] != 11'd0);
`else
    assign mul_iss = (state_q == S_MUL);
`endif
    assign add_iss = (state_q == S_ADD);

    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i < ALU_LAT - 1; i++) inflight = inflight | tv_q[i];
        sel = '0;
        for (int i = NTAPS - 1; i >= 0; i--) if (pend_q[i]) sel = AW'(i);
    end

    // First retiring product seeds the accumulator; later ones are queued in pend for adds.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        acc_d     = acc_q;
        acc_vld_d = acc_vld_q;
        if (ret_mul) begin
            if (acc_vld_q) begin
                pend_d[ti_q[ALU_LAT-1]] = 1'b1;
            end else begin
                acc_d     = prod_word;
                acc_vld_d = 1'b1;
            end
        end
        if (ret_add) acc_d = {alu_y_sgn_i, alu_y_exp_i, alu_y_man_dn_i};
        if (add_iss) pend_d[sel] = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d   = S_MUL;
                idx_d     = '0;
                pend_d    = '0;
                acc_d     = '0;
                acc_vld_d = 1'b0;
            end
            S_MUL: begin
                if (idx_q == AW'(NTAPS - 1)) begin
                    state_d = S_MWAIT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            S_MWAIT, S_AWAIT: if (!inflight) state_d = (pend_d != '0) ? S_ADD : S_DONE;
            S_ADD:   state_d = S_AWAIT;
            S_DONE:  if (y_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a_sgn_o    = 1'b0;
        alu_b_sgn_o    = 1'b0;
        alu_a_exp_o    = '0;
        alu_b_exp_o    = '0;
        alu_a_man_dn_o = '0;
        alu_b_man_dn_o = '0;
        alu_add_muln_o = 1'b0;
        if (mul_iss) begin
            alu_a_sgn_o    = coef_data_i[15];
            alu_a_exp_o    = {1'b0, coef_data_i[14:10]};
            alu_a_man_dn_o = {12'd0, coef_data_i[9:0]};
            alu_b_sgn_o    = smp_data_i[16];
            alu_b_exp_o    = {1'b0, smp_data_i[15:11]};
            alu_b_man_dn_o = {11'd0, smp_data_i[10:0]};
        end else if (add_iss) begin
            {alu_a_sgn_o, alu_a_exp_o, alu_a_man_dn_o} = acc_q;
            {alu_b_sgn_o, alu_b_exp_o, alu_b_man_dn_o} = prod_q[sel];
            alu_add_muln_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pend_q    <= '0;
            acc_q     <= '0;
            acc_vld_q <= 1'b0;
            tv_q      <= '0;
            tk_q      <= '0;
            ts_q      <= '0;
            for (int i = 0; i < ALU_LAT; i++) ti_q[i] <= '0;
            for (int i = 0; i < NTAPS; i++) prod_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            acc_q     <= acc_d;
            acc_vld_q <= acc_vld_d;
            for (int i = ALU_LAT - 1; i > 0; i--) begin
                tv_q[i] <= tv_q[i-1];
                tk_q[i] <= tk_q[i-1];
                ts_q[i] <= ts_q[i-1];
                ti_q[i] <= ti_q[i-1];
            end
            tv_q[0] <= mul_iss | add_iss;
            tk_q[0] <= add_iss;
            ts_q[0] <= coef_data_i[15] ^ smp_data_i[16];
            ti_q[0] <= add_iss ? sel : idx_q;
            if (ret_mul) prod_q[ti_q[ALU_LAT-1]] <= prod_word;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign y_valid_o   = (state_q == S_DONE);
    assign coef_addr_o = idx_q;
    assign smp_addr_o  = idx_q;
    assign y_sgn_o     = acc_q[28];
    assign y_exp_o     = acc_q[27:22];
    assign y_man_dn_o  = acc_q[21:0];

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq (NTAPS=8 and NTAPS=1 instances, ALU_LAT=4) with a toy
// 4-stage ALU: value = man_dn * 2^(exp-25), adds assume aligned exponents.
`timescale 1ns/1ps
module tb_fir_mac_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst, start, y_ready, start1, y_ready1;

    logic        busy, y_valid, y_sgn;
    logic [5:0]  y_exp;
    logic [21:0] y_man;
    logic [2:0]  coef_addr, smp_addr;
    logic [15:0] coef_data, coef_mem [8];
    logic [16:0] smp_data, smp_mem [8];
    logic        a_sgn, b_sgn, add_muln, r_sgn;
    logic [5:0]  a_exp, b_exp, r_exp;
    logic [21:0] a_man, b_man, r_man;
    logic [28:0] pipe [4];

    logic        busy1, y_valid1, y_sgn1;
    logic [5:0]  y_exp1;
    logic [21:0] y_man1;
    logic        coef_addr1, smp_addr1;
    logic [15:0] coef1;
    logic [16:0] smp1;
    logic        a_sgn1, b_sgn1, add_muln1, r_sgn1;
    logic [5:0]  a_exp1, b_exp1, r_exp1;
    logic [21:0] a_man1, b_man1, r_man1;
    logic [28:0] pipe1 [4];

    assign coef_data = coef_mem[coef_addr];
    assign smp_data  = smp_mem[smp_addr];
    assign {r_sgn, r_exp, r_man}    = pipe[3];
    assign {r_sgn1, r_exp1, r_man1} = pipe1[3];

    fir_mac_seq #(.NTAPS(8), .ALU_LAT(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy),
        .coef_addr_o(coef_addr), .smp_addr_o(smp_addr),
        .coef_data_i(coef_data), .smp_data_i(smp_data),
        .alu_a_sgn_o(a_sgn), .alu_b_sgn_o(b_sgn), .alu_a_exp_o(a_exp), .alu_b_exp_o(b_exp),
        .alu_a_man_dn_o(a_man), .alu_b_man_dn_o(b_man), .alu_add_muln_o(add_muln),
        .alu_y_sgn_i(r_sgn), .alu_y_exp_i(r_exp), .alu_y_man_dn_i(r_man),
        .y_valid_o(y_valid), .y_ready_i(y_ready),
        .y_sgn_o(y_sgn), .y_exp_o(y_exp), .y_man_dn_o(y_man));

    fir_mac_seq #(.NTAPS(1), .ALU_LAT(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .busy_o(busy1),
        .coef_addr_o(coef_addr1), .smp_addr_o(smp_addr1),
        .coef_data_i(coef1), .smp_data_i(smp1),
        .alu_a_sgn_o(a_sgn1), .alu_b_sgn_o(b_sgn1), .alu_a_exp_o(a_exp1), .alu_b_exp_o(b_exp1),
        .alu_a_man_dn_o(a_man1), .alu_b_man_dn_o(b_man1), .alu_add_muln_o(add_muln1),
        .alu_y_sgn_i(r_sgn1), .alu_y_exp_i(r_exp1), .alu_y_man_dn_i(r_man1),
        .y_valid_o(y_valid1), .y_ready_i(y_ready1),
        .y_sgn_o(y_sgn1), .y_exp_o(y_exp1), .y_man_dn_o(y_man1));

    // Multiply result sign is forced to 0 so the sequencer must supply it from the tag.
    function automatic logic [28:0] alu_f(input logic as, input logic [5:0] ae, input logic [21:0] am,
                                          input logic bs, input logic [5:0] be, input logic [21:0] bm,
                                          input logic add);
        int va, vb, s;
        logic [31:0] p;
        if (add) begin
            va = {10'd0, am};
            vb = {10'd0, bm};
            if (as) va = -va;
            if (bs) vb = -vb;
            s = va + vb;
            return {(s < 0), ((ae > be) ? ae : be), 22'((s < 0) ? -s : s)};
        end
        p = ((ae != 6'd0) ? (32'h400 | {22'd0, am[9:0]}) : {22'd0, am[9:0]}) * {21'd0, bm[10:0]};
        p = p >> 10;
        if (p == 32'd0) return 29'd0;
        return {1'b0, 6'(ae + be - 6'd15), 22'(p)};
    endfunction

    always @(posedge clk) begin
        pipe[0]  <= alu_f(a_sgn, a_exp, a_man, b_sgn, b_exp, b_man, add_muln);
        pipe1[0] <= alu_f(a_sgn1, a_exp1, a_man1, b_sgn1, b_exp1, b_man1, add_muln1);
        for (int k = 1; k < 4; k++) begin
            pipe[k]  <= pipe[k-1];
            pipe1[k] <= pipe1[k-1];
        end
    end

    localparam logic [15:0] C_P1 = 16'h3C00;
    localparam logic [15:0] C_M1 = 16'hBC00;
    localparam logic [28:0] Y_8  = {1'b0, 6'd15, 22'h2000};

    // Cycle 0 = start sampled; observations are taken mid-cycle n.
    task automatic run_main(input int budget, output int yv_cyc, output int n_mul, output int n_add,
                            output int first_mul, output int last_mul, output int first_add,
                            output int last_add, output logic [28:0] y);
        yv_cyc = -1; n_mul = 0; n_add = 0;
        first_mul = -1; last_mul = -1; first_add = -1; last_add = -1;
        y = '0;
        y_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy && !add_muln && a_exp != 6'd0) begin
                n_mul++;
                if (first_mul < 0) first_mul = n;
                last_mul = n;
            end
            if (add_muln) begin
                n_add++;
                if (first_add < 0) first_add = n;
                last_add = n;
            end
            if (y_valid) begin
                yv_cyc = n;
                y = {y_sgn, y_exp, y_man};
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; y_ready = 1'b0; y_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_yvalid: got %0b want 0", y_valid); end
        checks++; if ({y_sgn, y_exp, y_man} !== 29'd0) begin errors++; $display("FAIL reset_y: got %0h want 0", {y_sgn, y_exp, y_man}); end
        checks++; if ({a_sgn, b_sgn, a_exp, b_exp, a_man, b_man, add_muln} !== 59'd0) begin
            errors++; $display("FAIL reset_alu: got %0h want 0", {a_sgn, b_sgn, a_exp, b_exp, a_man, b_man, add_muln}); end
        checks++; if ({coef_addr, smp_addr} !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0h want 0", {coef_addr, smp_addr}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ones;
        int yv, nm, na, fm, lm, fa, la;
        logic [28:0] y;
        for (int i = 0; i < 8; i++) begin coef_mem[i] = C_P1; smp_mem[i] = {1'b0, 5'd15, 11'h400}; end
        run_main(80, yv, nm, na, fm, lm, fa, la, y);
        checks++; if (yv !== 48) begin errors++; $display("FAIL ones_yvalid_cycle: got %0d want 48", yv); end
        checks++; if (nm !== 8 || fm !== 1 || lm !== 8) begin errors++; $display("FAIL ones_muls: got n=%0d first=%0d last=%0d want 8 1 8", nm, fm, lm); end
        checks++; if (na !== 7 || fa !== 13 || la !== 43) begin errors++; $display("FAIL ones_adds: got n=%0d first=%0d last=%0d want 7 13 43", na, fa, la); end
        checks++; if (y !== Y_8) begin errors++; $display("FAIL ones_result: got %0h want %0h", y, Y_8); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ones_idle_after: got %0b want 0", busy); end
    endtask

    task automatic test_sign;
        int yv, nm, na, fm, lm, fa, la;
        logic [28:0] y;
        for (int i = 0; i < 8; i++) begin coef_mem[i] = 16'h0000; smp_mem[i] = 17'd0; end
        coef_mem[3] = C_M1;
        smp_mem[3]  = {1'b0, 5'd15, 11'h400};
        run_main(80, yv, nm, na, fm, lm, fa, la, y);
        checks++; if (y[28] !== 1'b1) begin errors++; $display("FAIL sign_ysgn: got %0b want 1", y[28]); end
        checks++; if (y !== {1'b1, 6'd15, 22'h400}) begin errors++; $display("FAIL sign_result: got %0h want %0h", y, {1'b1, 6'd15, 22'h400}); end
    endtask

    task automatic test_mixed;
        int yv, nm, na, fm, lm, fa, la;
        logic [28:0] y;
        for (int i = 0; i < 8; i++) begin coef_mem[i] = C_P1; smp_mem[i] = {1'b0, 5'd15, 11'(128 * (i + 1))}; end
        coef_mem[2] = C_M1;
        run_main(80, yv, nm, na, fm, lm, fa, la, y);
        checks++; if (y !== {1'b0, 6'd15, 22'hF00}) begin errors++; $display("FAIL mixed_result: got %0h want %0h", y, {1'b0, 6'd15, 22'hF00}); end
    endtask

    task automatic test_zero_taps;
        int yv, nm, na, fm, lm, fa, la;
        logic [28:0] y;
`ifdef FIR_SEQ_ZEROSKIP_EN
        int exp_mul = 5, exp_add = 4;
`else
        int exp_mul = 8, exp_add = 7;
`endif
        for (int i = 0; i < 8; i++) begin coef_mem[i] = C_P1; smp_mem[i] = {1'b0, 5'd15, 11'(128 * (i + 1))}; end
        smp_mem[1] = {1'b0, 5'd15, 11'd0};
        smp_mem[2] = {1'b0, 5'd15, 11'd0};
        smp_mem[5] = {1'b0, 5'd15, 11'd0};
        run_main(80, yv, nm, na, fm, lm, fa, la, y);
        checks++; if (nm !== exp_mul) begin errors++; $display("FAIL zero_muls: got %0d want %0d", nm, exp_mul); end
        checks++; if (na !== exp_add) begin errors++; $display("FAIL zero_adds: got %0d want %0d", na, exp_add); end
        checks++; if (y !== {1'b0, 6'd15, 22'hC80}) begin errors++; $display("FAIL zero_result: got %0h want %0h", y, {1'b0, 6'd15, 22'hC80}); end
    endtask

    task automatic test_back_to_back;
        logic [28:0] yh;
        logic seen;
        for (int i = 0; i < 8; i++) begin coef_mem[i] = C_P1; smp_mem[i] = {1'b0, 5'd15, 11'h400}; end
        y_ready = 1'b0;
        yh = '0;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 47) begin
                checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL bp_early_valid: got %0b want 0", y_valid); end
            end
            if (n == 48) begin
                checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise: got %0b want 1", y_valid); end
                yh = {y_sgn, y_exp, y_man};
            end
            if (n > 48 && n <= 58) begin
                checks++; if (y_valid !== 1'b1 || {y_sgn, y_exp, y_man} !== yh) begin
                    errors++; $display("FAIL bp_hold_c%0d: got v=%0b y=%0h want v=1 y=%0h", n, y_valid, {y_sgn, y_exp, y_man}, yh); end
            end
            if (n == 52) start = 1'b1;
            if (n == 58) y_ready = 1'b1;
            if (n == 59) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_c59: got %0b want 0", busy); end
                start = 1'b1;
            end
            if (n == 60) begin
                checks++; if (busy !== 1'b1 || add_muln !== 1'b0 || a_exp !== 6'd15) begin
                    errors++; $display("FAIL bp_restart_c60: got busy=%0b add=%0b aexp=%0d want 1 0 15", busy, add_muln, a_exp); end
            end
        end
        seen = 1'b0;
        for (int n = 0; n < 80 && !seen; n++) begin
            @(negedge clk);
            if (y_valid) begin seen = 1'b1; yh = {y_sgn, y_exp, y_man}; end
        end
        checks++; if (!seen || yh !== Y_8) begin errors++; $display("FAIL bp_second_result: got seen=%0b y=%0h want 1 %0h", seen, yh, Y_8); end
        @(negedge clk);
    endtask

    task automatic test_ntaps1;
        int yv, na;
        logic [28:0] y;
        coef1 = C_M1;
        smp1 = {1'b0, 5'd15, 11'h300};
        y_ready1 = 1'b1;
        yv = -1; na = 0; y = '0;
        @(negedge clk);
        start1 = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (add_muln1) na++;
            if (y_valid1) begin yv = n; y = {y_sgn1, y_exp1, y_man1}; break; end
        end
        checks++; if (yv !== 6) begin errors++; $display("FAIL n1_yvalid_cycle: got %0d want 6", yv); end
        checks++; if (na !== 0) begin errors++; $display("FAIL n1_adds: got %0d want 0", na); end
        checks++; if (y !== {1'b1, 6'd15, 22'h300}) begin errors++; $display("FAIL n1_result: got %0h want %0h", y, {1'b1, 6'd15, 22'h300}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int yv, nm, na, fm, lm, fa, la;
        logic [28:0] y;
        logic stray;
        for (int i = 0; i < 8; i++) begin coef_mem[i] = C_P1; smp_mem[i] = {1'b0, 5'd15, 11'h400}; end
        y_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 4) rst = 1'b1;
            if (n == 5) begin
                checks++; if (busy !== 1'b0 || y_valid !== 1'b0) begin errors++; $display("FAIL rmid_state: got busy=%0b v=%0b want 0 0", busy, y_valid); end
                checks++; if ({a_sgn, b_sgn, a_exp, b_exp, a_man, b_man, add_muln, coef_addr, smp_addr, y_sgn, y_exp, y_man} !== 94'd0) begin
                    errors++; $display("FAIL rmid_outputs: got %0h want 0", {a_sgn, b_sgn, a_exp, b_exp, a_man, b_man, add_muln, coef_addr, smp_addr, y_sgn, y_exp, y_man}); end
            end
            if (n == 6) rst = 1'b0;
        end
        stray = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (y_valid || busy) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rmid_no_activity: got %0b want 0", stray); end
        run_main(80, yv, nm, na, fm, lm, fa, la, y);
        checks++; if (yv !== 48 || y !== Y_8) begin errors++; $display("FAIL rmid_recover: got c=%0d y=%0h want 48 %0h", yv, y, Y_8); end
    endtask

    initial begin
        test_reset;
        test_ones;
        test_sign;
        test_mixed;
        test_zero_taps;
        test_back_to_back;
        test_ntaps1;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
